// File: rtl/matrix_pkg.sv
// Shared constants, state type and pixel bit-index helper for the 8x8 bicolour matrix.
`default_nettype none

package matrix_pkg;

  localparam int MATRIX_ROWS = 8;
  localparam int MATRIX_COLS = 8;
  localparam int FRAME_W     = 128;

  localparam logic [1:0] OFF    = 2'b00;
  localparam logic [1:0] RED    = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;
  localparam logic [1:0] YELLOW = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_t;

  // (7-r)*16 + 2c folds to {~r, c, 0} for 3-bit row/col.
  function automatic logic [6:0] pix_idx(input logic [2:0] row, input logic [2:0] col);
    return {~row, col, 1'b0};
  endfunction

  function automatic logic [6:0] row_base(input logic [2:0] row);
    return {~row, 4'b0000};
  endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_frame_buffer.sv
// 8x8 {G,R} frame buffer with row-by-row clear; MATRIX_FB_DOUBLE_BUF_EN adds a back buffer published by commit.
`default_nettype none

module matrix_frame_buffer
  import matrix_pkg::*;
#(
  parameter logic [1:0] CLEAR_COLOR = 2'b00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [2:0]         wr_row,
  input  logic [2:0]         wr_col,
  input  logic [1:0]         wr_color,
  input  logic               clr_req,
  input  logic               commit,
  output logic               busy,
  output logic               commit_done,
  output logic [FRAME_W-1:0] frame
);

  fb_state_t          state;
  logic [2:0]         clr_row;
  logic [FRAME_W-1:0] buf_wr;

`ifdef MATRIX_FB_DOUBLE_BUF_EN
  logic [FRAME_W-1:0] back;
`endif

  assign wr_ready = (state == IDLE);
  assign busy     = (state == CLEAR);

  // Working buffer with this cycle's write merged in, so commit sees it too.
  always_comb begin
`ifdef MATRIX_FB_DOUBLE_BUF_EN
    buf_wr = back;
`else
    buf_wr = frame;
`endif
    if (wr_valid && (state == IDLE))
      buf_wr[pix_idx(wr_row, wr_col) +: 2] = wr_color;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      clr_row     <= 3'd0;
      commit_done <= 1'b0;
      frame       <= '0;
`ifdef MATRIX_FB_DOUBLE_BUF_EN
      back        <= '0;
`endif
    end else begin
      commit_done <= 1'b0;
      case (state)
        IDLE: begin
`ifdef MATRIX_FB_DOUBLE_BUF_EN
          back <= buf_wr;
          if (commit)
            frame <= buf_wr;
`else
          frame <= buf_wr;
`endif
          if (commit)
            commit_done <= 1'b1;
          if (clr_req) begin
            state   <= CLEAR;
            clr_row <= 3'd0;
          end
        end
        CLEAR: begin
`ifdef MATRIX_FB_DOUBLE_BUF_EN
          back[row_base(clr_row) +: 16] <= {8{CLEAR_COLOR}};
`else
          frame[row_base(clr_row) +: 16] <= {8{CLEAR_COLOR}};
`endif
          clr_row <= clr_row + 3'd1;
          if (clr_row == 3'd7)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_matrix_frame_buffer.sv
// Self-checking bench: array-based pixel model compared every cycle, plus literal directed checks.
`default_nettype none

module tb_matrix_frame_buffer;
  import matrix_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_valid, wr_ready;
  logic [2:0]   wr_row, wr_col;
  logic [1:0]   wr_color;
  logic         clr_req, commit, busy, commit_done;
  logic [127:0] frame;

  matrix_frame_buffer #(.CLEAR_COLOR(2'b00)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_row(wr_row), .wr_col(wr_col), .wr_color(wr_color),
    .clr_req(clr_req), .commit(commit), .busy(busy),
    .commit_done(commit_done), .frame(frame)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] mback [8][8];
  logic [1:0] mfrm  [8][8];
  int         cnt;
  bit         mdone;

  function automatic logic [127:0] mframe();
    logic [127:0] f = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        f[(7 - r) * 16 + 2 * c +: 2] = mfrm[r][c];
    return f;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_step();
    mdone = 0;
    if (rst) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          mback[r][c] = 2'b00;
          mfrm[r][c]  = 2'b00;
        end
      cnt = 0;
    end else if (cnt > 0) begin
      for (int c = 0; c < 8; c++) mback[8 - cnt][c] = 2'b00;
      cnt--;
    end else begin
      if (wr_valid) mback[wr_row][wr_col] = wr_color;
      if (commit) begin
`ifdef MATRIX_FB_DOUBLE_BUF_EN
        mfrm = mback;
`endif
        mdone = 1;
      end
      if (clr_req) cnt = 8;
    end
`ifndef MATRIX_FB_DOUBLE_BUF_EN
    mfrm = mback;
`endif
  endtask

  task automatic check_all();
    chk("frame", frame, mframe());
    chk("wr_ready", wr_ready, cnt == 0);
    chk("busy", busy, cnt != 0);
    chk("commit_done", commit_done, mdone);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic v, input logic [2:0] r, input logic [2:0] c,
                       input logic [1:0] col, input logic cl, input logic cm);
    wr_valid = v; wr_row = r; wr_col = c; wr_color = col; clr_req = cl; commit = cm;
  endtask

  task automatic idle_in();
    drive(1'b0, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0);
  endtask

  // Called at a negedge; asserts reset mid-cycle and checks the asynchronous effect.
  task automatic async_reset(input string nm);
    idle_in();
    #2 rst = 1'b1;
    #1;
    chk({nm, "_frame"}, frame, 128'd0);
    chk({nm, "_done"}, commit_done, 1'b0);
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_ready"}, wr_ready, 1'b1);
    model_step();
    @(negedge clk);
    rst = 1'b0;
    check_all();
  endtask

  int n;

  initial begin
    rst = 1'b1;
    idle_in();
    model_step();
    @(negedge clk);
    @(negedge clk);
    chk("reset_frame", frame, 128'd0);
    chk("reset_ready", wr_ready, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", commit_done, 1'b0);
    rst = 1'b0;
    cycle();

    // Write r0c0 RED with same-cycle commit
    drive(1'b1, 3'd0, 3'd0, RED, 1'b0, 1'b1);
    cycle();
    chk("t_red_frame", frame, 128'd1 << 112);
    chk("t_red_done", commit_done, 1'b1);
    idle_in();
    cycle();
    chk("t_red_done_once", commit_done, 1'b0);

`ifdef MATRIX_FB_DOUBLE_BUF_EN
    async_reset("rst_a");
    drive(1'b1, 3'd7, 3'd7, YELLOW, 1'b0, 1'b0);
    cycle();
    chk("t_yel_nocommit", frame, 128'd0);
    drive(1'b0, 3'd0, 3'd0, 2'b00, 1'b0, 1'b1);
    cycle();
    chk("t_yel_commit", frame, 128'd3 << 14);
    idle_in();
    cycle();
    cycle();
    chk("t_commit_again", frame, 128'd3 << 14);

    async_reset("rst_b");
    drive(1'b1, 3'd3, 3'd4, RED, 1'b0, 1'b1);
    cycle();
    chk("t_bypass", frame, 128'd1 << 72);
    drive(1'b1, 3'd0, 3'd0, YELLOW, 1'b1, 1'b1);
    cycle();
    chk("t_commit_clr", frame, (128'd1 << 72) | (128'd3 << 112));
    idle_in();
    for (int i = 0; i < 9; i++) cycle();
    chk("t_preclear_held", frame, (128'd1 << 72) | (128'd3 << 112));
    drive(1'b0, 3'd0, 3'd0, 2'b00, 1'b0, 1'b1);
    cycle();
    chk("t_cleared_commit", frame, 128'd0);
`else
    async_reset("rst_a");
    drive(1'b1, 3'd2, 3'd1, GREEN, 1'b0, 1'b0);
    cycle();
    chk("t_direct_write", frame, 128'd1 << 83);
`endif

    // Fill with GREEN, commit, clear; commit issued mid-clear must be ignored
    async_reset("rst_c");
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        drive(1'b1, r[2:0], c[2:0], GREEN, 1'b0, 1'b0);
        cycle();
      end
    drive(1'b0, 3'd0, 3'd0, 2'b00, 1'b0, 1'b1);
    cycle();
    chk("t_fill_green", frame, {64{2'b10}});
    drive(1'b0, 3'd0, 3'd0, 2'b00, 1'b1, 1'b0);
    cycle();
    idle_in();
    n = 0;
    while (busy && n < 20) begin
      commit = (n == 3);
      cycle();
      if (n == 3) chk("t_commit_in_clear", commit_done, 1'b0);
      n++;
    end
    commit = 1'b0;
    chk("t_clear_len", n, 8);
    chk("t_ready_after", wr_ready, 1'b1);
`ifdef MATRIX_FB_DOUBLE_BUF_EN
    chk("t_green_held", frame, {64{2'b10}});
    commit = 1'b1;
    cycle();
    commit = 1'b0;
`endif
    chk("t_cleared", frame, 128'd0);

    // Reset during the 4th clear cycle
    drive(1'b1, 3'd5, 3'd5, RED, 1'b0, 1'b1);
    cycle();
    drive(1'b0, 3'd0, 3'd0, 2'b00, 1'b1, 1'b0);
    cycle();
    idle_in();
    cycle();
    cycle();
    cycle();
    async_reset("rst_midclear");

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom % 2) == 0, 3'($urandom), 3'($urandom), 2'($urandom),
            ($urandom % 20) == 0, ($urandom % 6) == 0);
      rst = (($urandom % 200) == 0);
      cycle();
    end
    rst = 1'b0;
    idle_in();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/matrix_frame_buffer.md
MATRIX_FRAME_BUFFER -- requirements
Module: matrix_frame_buffer

Interface
REQ-001 Parameter CLEAR_COLOR, default 2'b00, {G,R} value written to every pixel by a clear.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 wr_valid  input  1  pixel write request.
REQ-005 wr_ready  output  1  block can accept a pixel write this cycle.
REQ-006 wr_row  input  3  target row, 0..7.
REQ-007 wr_col  input  3  target column, 0..7.
REQ-008 wr_color  input  2  {G,R} pixel value, 1 = LED on.
REQ-009 clr_req  input  1  single-cycle request to clear the back buffer.
REQ-010 commit  input  1  single-cycle request to publish the back buffer to frame.
REQ-011 busy  output  1  high while a clear is in progress.
REQ-012 commit_done  output  1  one-cycle pulse, the cycle after a commit takes effect.
REQ-013 frame  output  128  displayed image to the matrix driver, registered.

Function
REQ-014 Pixel (r,c) SHALL map to frame bits R = [(7-r)*16 + 2c] and G = [(7-r)*16 + 2c + 1], so row 0 occupies [127:112].
REQ-015 FSM states SHALL be IDLE and CLEAR; wr_ready = (state == IDLE); busy = (state == CLEAR).
REQ-016 A write SHALL be accepted when wr_valid && wr_ready and SHALL update only the 2 bits of (wr_row, wr_col) in the back buffer at that edge.
REQ-017 In IDLE, clr_req SHALL move the FSM to CLEAR; CLEAR SHALL last exactly 8 cycles, setting back-buffer row k to CLEAR_COLOR in every pixel on the k-th cycle (k = 0..7), then return to IDLE.
REQ-018 A write and clr_req in the same IDLE cycle: the write SHALL be applied, and the clear then overwrites it.
REQ-019 In IDLE, commit SHALL load frame with the back-buffer value, including a write accepted in the same cycle (bypass), at that edge; commit_done SHALL pulse on the following cycle.
REQ-020 commit and clr_req in the same IDLE cycle: the commit SHALL be performed first (frame gets the pre-clear contents) and the clear SHALL start.
REQ-021 clr_req and commit arriving while in CLEAR SHALL be ignored: no queueing and no commit_done.
REQ-022 wr_valid while wr_ready is low SHALL not be accepted; the requester holds the request until acceptance.
REQ-023 The back buffer SHALL NOT change on commit; consecutive commits with no writes SHALL leave frame unchanged.

Reset
REQ-024 rst SHALL asynchronously force state = IDLE, back buffer = 0, frame = 0, commit_done = 0; after release wr_ready = 1 and busy = 0.
REQ-025 rst asserted mid-clear SHALL abort the clear; no partial-row state survives.

Configuration
REQ-026 With MATRIX_FB_DOUBLE_BUF_EN defined, REQ-016 to REQ-023 SHALL apply as written (separate back buffer and frame registers).
REQ-027 Without MATRIX_FB_DOUBLE_BUF_EN, there SHALL be no back buffer: writes and clears act on frame directly (visible on the next cycle), and commit only produces the commit_done pulse.

Structure
REQ-028 A shared package matrix_pkg SHALL hold MATRIX_ROWS = 8, MATRIX_COLS = 8, FRAME_W = 128, the {G,R} colour constants (OFF = 00, RED = 01, GREEN = 10, YELLOW = 11), and the FSM state type.
REQ-029 No sub-module is required; the bit-index function of REQ-014 SHALL live in matrix_pkg for reuse by the driver bench.

Verification
REQ-030 Reset, write (r0,c0,RED), commit -> frame = 128'h0001_0000...0000 (bit 112 set) and commit_done pulses exactly one cycle later.
REQ-031 Write (r7,c7,YELLOW) with no commit -> frame stays 0 (double-buffer build); after commit, frame[15:14] = 2'b11 and all other bits are 0.
REQ-032 Fill all 64 pixels with GREEN, commit, then clr_req with CLEAR_COLOR = 00 -> busy and !wr_ready for exactly 8 cycles; frame stays all-GREEN until the next commit, after which it is 0.
REQ-033 Same-cycle write (r3,c4,RED) plus commit -> frame[(7-3)*16+8] = 1 at that edge; same-cycle commit plus clr_req -> frame holds the pre-clear image.
REQ-034 Assert rst at the 4th CLEAR cycle -> all outputs 0, wr_ready = 1 after release; a commit during CLEAR produces no commit_done.
REQ-035 Build without MATRIX_FB_DOUBLE_BUF_EN: write (r2,c1,GREEN) -> frame bit (5*16+3) is set one cycle later with no commit.
